// File: rtl/rv32_bus_arbiter.sv
// Purpose: merges the rv32 instruction and data buses onto one shared memory bus with
//          round-robin arbitration and a watchdog that turns a hung access into a fault.
// Ports:   clk/reset (sync, active-high); instr_* fetch master; data_* load/store master;
//          mem_* shared bus. Grant is registered (1 cycle request-to-bus); mem_* and the
//          ready/fault/read-value returns are combinational from the registered grant.
module rv32_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_address_in,
  input  logic        instr_read_in,
  output logic [31:0] instr_read_value_out,
  output logic        instr_ready_out,
  output logic        instr_fault_out,
  input  logic [31:0] data_address_in,
  input  logic        data_read_in,
  input  logic        data_write_in,
  input  logic [3:0]  data_write_mask_in,
  input  logic [31:0] data_write_value_in,
  output logic [31:0] data_read_value_out,
  output logic        data_ready_out,
  output logic        data_fault_out,
  output logic [31:0] mem_address_out,
  output logic        mem_read_out,
  output logic        mem_write_out,
  output logic [3:0]  mem_write_mask_out,
  output logic [31:0] mem_write_value_out,
  input  logic [31:0] mem_read_value_in,
  input  logic        mem_ready_in,
  input  logic        mem_fault_in
);

  localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
  localparam int CW    = WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = WD_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, GRANT_INSTR, GRANT_DATA} state_t;

  state_t        state;
  logic          last_grant_data;  // 1: data was the last master served
  logic [CW-1:0] counter;

  logic instr_req, data_req;
  logic grant_instr, grant_data, granted;
  logic cur_req, done, timeout;

  assign instr_req = instr_read_in;
  assign data_req  = data_read_in | data_write_in;

  // Gating with reset forces every output low while reset is held, even mid-grant.
  assign grant_instr = (state == GRANT_INSTR) & ~reset;
  assign grant_data  = (state == GRANT_DATA)  & ~reset;
  assign granted     = grant_instr | grant_data;
  assign cur_req     = grant_instr ? instr_req : data_req;
  assign done        = mem_ready_in | mem_fault_in;

  // A master that has already dropped its request is aborting, not timing out.
  assign timeout = WD_EN & granted & cur_req & ~done & (counter == CNT_LAST);

  // Fault wins over a simultaneous ready.
  assign instr_ready_out = grant_instr & mem_ready_in & ~mem_fault_in;
  assign data_ready_out  = grant_data  & mem_ready_in & ~mem_fault_in;
  assign instr_fault_out = grant_instr & (mem_fault_in | timeout);
  assign data_fault_out  = grant_data  & (mem_fault_in | timeout);

  assign instr_read_value_out = grant_instr ? mem_read_value_in : 32'h0;
  assign data_read_value_out  = grant_data  ? mem_read_value_in : 32'h0;

  always_comb begin
    mem_address_out     = 32'h0;
    mem_read_out        = 1'b0;
    mem_write_out       = 1'b0;
    mem_write_mask_out  = 4'h0;
    mem_write_value_out = 32'h0;
    if (grant_instr) begin
      mem_address_out = instr_address_in;
      mem_read_out    = instr_read_in;
    end else if (grant_data) begin
      mem_address_out     = data_address_in;
      mem_read_out        = data_read_in;
      mem_write_out       = data_write_in;
      mem_write_mask_out  = data_write_mask_in;
      mem_write_value_out = data_write_value_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      last_grant_data <= 1'b1;  // instr wins the first contention
      counter         <= '0;
    end else begin
      case (state)
        IDLE: begin
          counter <= '0;
          if (instr_req && (!data_req || last_grant_data))
            state <= GRANT_INSTR;
          else if (data_req)
            state <= GRANT_DATA;
        end
        GRANT_INSTR, GRANT_DATA: begin
          // Completion, watchdog expiry and abort all release the bus the same way.
          if (done || timeout || !cur_req) begin
            state           <= IDLE;
            last_grant_data <= (state == GRANT_DATA);
            counter         <= '0;
          end else if (counter != CNT_MAX) begin
            counter <= counter + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
